multicycle_control: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It is the stage directly upstream of `alu_control`: it sequences each instruction through fetch, decode, execute, memory and writeback, and drives `ALUop[2:0]`. `ALUop = 3'b111` tells `alu_control` to decode `funct`; any other value is passed straight through as the ALU operation. It also handshakes with a variable-latency memory and counts retired instructions.

---
 rtl/multicycle_control_if.sv | 47 ++++
 rtl/multicycle_control.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_if
// Description : Control/status bundle between the multicycle MIPS control FSM
//               (master) and the datapath/memory side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_if #(
  parameter int RETIRE_W = 32
);
  logic [5:0]          opcode;
  logic                zero;
  logic                mem_ready;
  logic [2:0]          ALUop;
  logic                pc_write;
  logic                ir_write;
  logic                mem_read;
  logic                mem_write;
  logic                i_or_d;
  logic                reg_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          pc_src;
  logic                illegal_op;
  logic                retire;
  logic [RETIRE_W-1:0] retired_count;
  logic [3:0]          state;

  // Control FSM side: consumes IR opcode / flags, drives all control lines.
  modport master (
    input  opcode, zero, mem_ready,
    output ALUop, pc_write, ir_write, mem_read, mem_write, i_or_d,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src,
           illegal_op, retire, retired_count, state
  );

  // Datapath side: mirror image of the master.
  modport slave (
    output opcode, zero, mem_ready,
    input  ALUop, pc_write, ir_write, mem_read, mem_write, i_or_d,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src,
           illegal_op, retire, retired_count, state
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Main control FSM for the multicycle MIPS datapath. Sequences
//               fetch/decode/execute/memory/writeback, handshakes with a
//               variable-latency memory and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int RETIRE_W = 32
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_I_EXEC    = 4'd11,
    S_I_WB      = 4'd12
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_SLTI  = 6'b001010;

  localparam logic [2:0] c_ALU_AND   = 3'b000;
  localparam logic [2:0] c_ALU_OR    = 3'b001;
  localparam logic [2:0] c_ALU_SLT   = 3'b100;
  localparam logic [2:0] c_ALU_ADD   = 3'b101;
  localparam logic [2:0] c_ALU_SUB   = 3'b110;
  localparam logic [2:0] c_ALU_FUNCT = 3'b111;

  state_t              r_state;
  logic [RETIRE_W-1:0] r_retired_count;
  logic                w_retire;

  // State register: opcode is only consulted in DECODE and MEM_ADDR, and
  // mem_ready only in the three memory-access states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:      r_state <= S_FETCH;
        S_FETCH:     r_state <= bus.mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (bus.opcode)
            c_OP_LW, c_OP_SW:                        r_state <= S_MEM_ADDR;
            c_OP_RTYPE:                              r_state <= S_R_EXEC;
            c_OP_BEQ:                                r_state <= S_BRANCH;
            c_OP_J:                                  r_state <= S_JUMP;
            c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_SLTI: r_state <= S_I_EXEC;
            default:                                 r_state <= S_FETCH;
          endcase
        end
        S_MEM_ADDR:  r_state <= (bus.opcode == c_OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  r_state <= bus.mem_ready ? S_MEM_WB : S_MEM_READ;
        S_MEM_WRITE: r_state <= bus.mem_ready ? S_FETCH : S_MEM_WRITE;
        S_R_EXEC:    r_state <= S_R_WB;
        S_I_EXEC:    r_state <= S_I_WB;
        S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: r_state <= S_FETCH;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  // Retired-instruction counter; wraps naturally at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired_count <= '0;
    end else if (w_retire) begin
      r_retired_count <= r_retired_count + 1'b1;
    end
  end

  // Per-state control decode; everything defaults to 0 with ALUop = ADD.
  always_comb begin
    bus.ALUop      = c_ALU_ADD;
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.pc_src     = 2'b00;
    bus.illegal_op = 1'b0;
    w_retire       = 1'b0;
    case (r_state)
      S_IDLE: bus.ALUop = 3'b000;
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          c_OP_RTYPE, c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_J,
          c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_SLTI: bus.illegal_op = 1'b0;
          default:                                   bus.illegal_op = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        w_retire      = bus.mem_ready;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        w_retire       = 1'b1;
      end
      S_R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.ALUop     = c_ALU_FUNCT;
      end
      S_R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        w_retire      = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.ALUop     = c_ALU_SUB;
        bus.pc_src    = 2'b01;
        bus.pc_write  = bus.zero;
        w_retire      = 1'b1;
      end
      S_JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = 2'b10;
        w_retire     = 1'b1;
      end
      S_I_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        case (bus.opcode)
          c_OP_ANDI: bus.ALUop = c_ALU_AND;
          c_OP_ORI:  bus.ALUop = c_ALU_OR;
          c_OP_SLTI: bus.ALUop = c_ALU_SLT;
          default:   bus.ALUop = c_ALU_ADD;
        endcase
      end
      S_I_WB: begin
        bus.reg_write = 1'b1;
        w_retire      = 1'b1;
      end
      default: bus.ALUop = 3'b000;
    endcase
  end

  assign bus.retire        = w_retire;
  assign bus.retired_count = r_retired_count;
  assign bus.state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control: directed vector
//               table, reset corner cases, and randomized instruction stream
//               against a per-instruction reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  localparam int RW = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if #(.RETIRE_W(RW)) bus ();
  multicycle_control #(.RETIRE_W(RW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int cycles; int retires; int illegals; int pcw; int mrd;
    int iord; int mwr; int rw; int alu; int path_ok; int cnt_start;
  } meas_t;

  typedef struct {
    logic [5:0] op; int fw; int mw; bit z;
    int cycles; int alu; int retires; int pcw;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_count = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
  endfunction

  // Instruction-level reference: what a whole instruction must produce.
  function automatic meas_t model(input logic [5:0] op, input int fw, input int mw, input bit z);
    meas_t e;
    bit lw = (op == OP_LW), sw = (op == OP_SW);
    int base;
    case (op)
      OP_LW:                          base = 5;
      OP_BEQ, OP_J:                   base = 3;
      OP_R, OP_SW, OP_ADDI, OP_ANDI,
      OP_ORI, OP_SLTI:                base = 4;
      default:                        base = 2;
    endcase
    case (op)
      OP_R:    e.alu = 7;
      OP_BEQ:  e.alu = 6;
      OP_ANDI: e.alu = 0;
      OP_ORI:  e.alu = 1;
      OP_SLTI: e.alu = 4;
      default: e.alu = 5;
    endcase
    e.cycles   = base + fw + ((lw || sw) ? mw : 0);
    e.retires  = is_legal(op) ? 1 : 0;
    e.illegals = is_legal(op) ? 0 : 1;
    e.pcw      = 1 + (op == OP_J ? 1 : 0) + ((op == OP_BEQ && z) ? 1 : 0);
    e.mrd      = fw + 1 + (lw ? mw + 1 : 0);
    e.iord     = (lw || sw) ? mw + 1 : 0;
    e.mwr      = sw ? mw + 1 : 0;
    e.rw       = (lw || op inside {OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI}) ? 1 : 0;
    e.path_ok  = 1;
    e.cnt_start = exp_count;
    return e;
  endfunction

  // Drive one instruction starting at its first FETCH cycle and collect
  // what the DUT did. fw/mw are wait cycles in FETCH and in the data access.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input bit z, output meas_t m);
    int  path[$];
    bit  mem = (op == OP_LW || op == OP_SW);
    int  alu_idx;
    for (int i = 0; i <= fw; i++) path.push_back(1);
    path.push_back(2);
    case (op)
      OP_LW: begin path.push_back(3); for (int i = 0; i <= mw; i++) path.push_back(4); path.push_back(5); end
      OP_SW: begin path.push_back(3); for (int i = 0; i <= mw; i++) path.push_back(6); end
      OP_R:  begin path.push_back(7); path.push_back(8); end
      OP_BEQ: path.push_back(9);
      OP_J:   path.push_back(10);
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin path.push_back(11); path.push_back(12); end
      default: ;
    endcase
    alu_idx = (fw + 2 < path.size()) ? fw + 2 : path.size() - 1;
    m = '{default: 0};
    m.path_ok = 1;
    for (int c = 0; c < path.size(); c++) begin
      @(posedge clk); #1;
      if (c == 0) bus.opcode = op;
      if (c < fw)                                   bus.mem_ready = 1'b0;
      else if (c == fw)                             bus.mem_ready = 1'b1;
      else if (mem && c >= fw + 3 && c < fw + 3 + mw) bus.mem_ready = 1'b0;
      else if (mem && c == fw + 3 + mw)             bus.mem_ready = 1'b1;
      else                                          bus.mem_ready = 1'($urandom_range(0, 1));
      bus.zero = (c == fw + 2) ? z : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (c == 0) m.cnt_start = int'(bus.retired_count);
      if (int'(bus.state) != path[c]) m.path_ok = 0;
      if ((bus.retire || bus.illegal_op) && m.cycles == 0) m.cycles = c + 1;
      m.retires  += int'(bus.retire);
      m.illegals += int'(bus.illegal_op);
      m.pcw      += int'(bus.pc_write);
      m.mrd      += int'(bus.mem_read);
      m.iord     += int'(bus.i_or_d);
      m.mwr      += int'(bus.mem_write);
      m.rw       += int'(bus.reg_write);
      if (c == alu_idx) m.alu = int'(bus.ALUop);
    end
  endtask

  task automatic cmp_model(input string tag, input meas_t m, input meas_t e);
    check($sformatf("%s path", tag),     m.path_ok,   e.path_ok);
    check($sformatf("%s cycles", tag),   m.cycles,    e.cycles);
    check($sformatf("%s retire", tag),   m.retires,   e.retires);
    check($sformatf("%s illegal", tag),  m.illegals,  e.illegals);
    check($sformatf("%s pc_write", tag), m.pcw,       e.pcw);
    check($sformatf("%s mem_read", tag), m.mrd,       e.mrd);
    check($sformatf("%s i_or_d", tag),   m.iord,      e.iord);
    check($sformatf("%s mem_write", tag), m.mwr,      e.mwr);
    check($sformatf("%s reg_write", tag), m.rw,       e.rw);
    check($sformatf("%s ALUop", tag),    m.alu,       e.alu);
    check($sformatf("%s count", tag),    m.cnt_start, e.cnt_start);
  endtask

  function automatic int all_outputs();
    return int'({bus.ALUop, bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write,
                 bus.i_or_d, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                 bus.alu_src_b, bus.pc_src, bus.illegal_op, bus.retire});
  endfunction

  vec_t  vecs[$];
  meas_t m, e;

  initial begin
    bus.opcode = OP_R; bus.zero = 1'b1; bus.mem_ready = 1'b1;

    // Reset held 3 cycles: IDLE, all outputs low, counter cleared.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset state", int'(bus.state), 0);
      check("reset outputs", all_outputs(), 0);
      check("reset count", int'(bus.retired_count), 0);
    end
    rst_n = 1'b1;

    // {op, fetch waits, mem waits, zero, cycles, ALUop in 3rd phase, retires, pc_write pulses}
    vecs.push_back('{OP_R,    0, 0, 1'b0, 4, 7, 1, 1});
    vecs.push_back('{OP_LW,   2, 2, 1'b0, 9, 5, 1, 1});
    vecs.push_back('{OP_BEQ,  0, 0, 1'b1, 3, 6, 1, 2});
    vecs.push_back('{OP_BEQ,  0, 0, 1'b0, 3, 6, 1, 1});
    vecs.push_back('{6'h3F,   0, 0, 1'b0, 2, 5, 0, 1});
    vecs.push_back('{OP_ORI,  0, 0, 1'b0, 4, 1, 1, 1});
    vecs.push_back('{OP_SLTI, 0, 0, 1'b0, 4, 4, 1, 1});
    vecs.push_back('{OP_ADDI, 1, 0, 1'b0, 5, 5, 1, 1});
    vecs.push_back('{OP_ANDI, 0, 0, 1'b0, 4, 0, 1, 1});
    vecs.push_back('{OP_SW,   0, 1, 1'b0, 5, 5, 1, 1});
    vecs.push_back('{OP_J,    0, 0, 1'b0, 3, 5, 1, 2});
    foreach (vecs[i]) begin
      e = model(vecs[i].op, vecs[i].fw, vecs[i].mw, vecs[i].z);
      run_instr(vecs[i].op, vecs[i].fw, vecs[i].mw, vecs[i].z, m);
      check($sformatf("vec%0d cycles", i), m.cycles,  vecs[i].cycles);
      check($sformatf("vec%0d ALUop", i),  m.alu,     vecs[i].alu);
      check($sformatf("vec%0d retire", i), m.retires, vecs[i].retires);
      check($sformatf("vec%0d pc_write", i), m.pcw,   vecs[i].pcw);
      cmp_model($sformatf("vec%0d", i), m, e);
      exp_count = (exp_count + e.retires) % (1 << RW);
    end

    // Reset dropped in the middle of a stalled sw.
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (c == 0) bus.opcode = OP_SW;
      bus.mem_ready = (c == 3) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    check("midwrite state", int'(bus.state), 6);
    check("midwrite mem_write", int'(bus.mem_write), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset state", int'(bus.state), 0);
    check("async reset mem_write", int'(bus.mem_write), 0);
    check("async reset retire", int'(bus.retire), 0);
    check("async reset count", int'(bus.retired_count), 0);
    repeat (2) @(negedge clk);
    check("reset hold outputs", all_outputs(), 0);
    rst_n = 1'b1;
    exp_count = 0;

    // Counter wrap: 16 retires on a 4-bit counter returns to 0.
    for (int i = 0; i < 16; i++) begin
      run_instr(OP_J, 0, 0, 1'b0, m);
      if (i == 15) check("count before wrap", m.cnt_start, 15);
    end
    exp_count = 0;

    // Randomized instruction stream.
    for (int i = 0; i < 150; i++) begin
      logic [5:0] op;
      int fw, mw, k;
      bit z;
      logic [5:0] legal_ops [9] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
      k = $urandom_range(0, 10);
      if (k < 9) op = legal_ops[k];
      else begin
        op = 6'($urandom_range(0, 63));
        while (is_legal(op)) op = 6'($urandom_range(0, 63));
      end
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      z  = 1'($urandom_range(0, 1));
      e = model(op, fw, mw, z);
      run_instr(op, fw, mw, z, m);
      if (i == 0) check("count after wrap", m.cnt_start, 0);
      cmp_model($sformatf("rnd%0d op=%b", i, op), m, e);
      exp_count = (exp_count + e.retires) % (1 << RW);
    end

    @(posedge clk); #1;
    @(negedge clk);
    check("final state", int'(bus.state), 1);
    check("final count", int'(bus.retired_count), exp_count);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
